// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART transmitter between NUM_REQ byte
// sources. Each source offers bytes on a valid/ready stream. The arbiter picks
// one winner and hands its byte to the transmitter with a one-cycle t_start
// pulse. It then waits for t_done_tick, or gives up after TIMEOUT_TICKS baud
// ticks and flags an error. Before the next grant it holds an idle gap of
// GAP_TICKS baud ticks.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester "byte available"
//   req_data     requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_ready    one-hot, one-cycle pulse: byte of that requester accepted
//   s_tick       baud oversample tick, shared with the transmitter
//   t_done_tick  transmitter frame-complete pulse
//   t_start      one-cycle start pulse to the transmitter
//   tx_data      byte for the transmitter, held until the next grant
//   grant_id     index of the requester currently or last served
//   busy         high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse when the transmitter never completed
//
// All outputs are registered. No combinational path runs from req_valid to
// req_ready.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 256,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           s_tick,
    input  logic                           t_done_tick,
    output logic                           t_start,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    // One counter width serves both the gap and the timeout counter.
    localparam int CNT_MAX = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_TICKS);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state_reg;
    logic [ID_W-1:0]    ptr_reg;
    logic [CNT_W-1:0]   tick_cnt_reg;
    logic [CNT_W-1:0]   gap_cnt_reg;

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]   at_or_after;
    logic [NUM_REQ-1:0]   masked_valid;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [ID_W-1:0]      win_id;
    logic                 win_found;
    logic [DATA_BITS-1:0] win_data;
    logic [ID_W-1:0]      ptr_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi]   = req_data[gi*DATA_BITS +: DATA_BITS];
            // Requesters at or above the pointer form the high-priority half.
            assign at_or_after[gi] = (ID_W'(gi) >= ptr_reg);
            assign win_onehot[gi]  = win_found && (win_id == ID_W'(gi));
        end
    endgenerate

    assign masked_valid = req_valid & at_or_after;

    // The lowest set bit of masked_valid is the first valid requester at or
    // after the pointer. If that half is empty, the search wraps to the lowest
    // set bit of the full valid vector. Loops run downward so the last hit is
    // the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked_valid[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    assign win_data = req_bytes[win_id];
    assign ptr_next = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

    // ------------------------------------------------------------------
    // Tick counters. They saturate instead of wrapping.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_next;
    logic [CNT_W-1:0] gap_next;

    always_comb begin
        tick_next = tick_cnt_reg;
        gap_next  = gap_cnt_reg;
        if (s_tick && (tick_cnt_reg != {CNT_W{1'b1}})) begin
            tick_next = tick_cnt_reg + 1'b1;
        end
        if (s_tick && (gap_cnt_reg != {CNT_W{1'b1}})) begin
            gap_next = gap_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            tick_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            req_ready    <= '0;
            t_start      <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // Pulse outputs default low. tx_data and grant_id hold their value.
            req_ready   <= '0;
            t_start     <= 1'b0;
            timeout_err <= 1'b0;

            unique case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        tx_data      <= win_data;
                        grant_id     <= win_id;
                        req_ready    <= win_onehot;
                        t_start      <= 1'b1;
                        ptr_reg      <= ptr_next;
                        tick_cnt_reg <= '0;
                        busy         <= 1'b1;
                        state_reg    <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    // A tick in the same cycle as done is still counted. Done
                    // takes priority over a timeout in that same cycle.
                    tick_cnt_reg <= tick_next;
                    if (t_done_tick) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end else if (tick_next >= TIMEOUT_LIM) begin
                        timeout_err <= 1'b1;
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end
                end

                GAP: begin
                    // With GAP_TICKS = 0 the check succeeds on the first
                    // cycle, so the gap lasts one clock.
                    if (gap_cnt_reg == GAP_LIM) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_next;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        s_tick = 1'b0;
    logic        t_done_tick = 1'b0;
    logic        t_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .GAP_TICKS(16), .TIMEOUT_TICKS(256)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .s_tick(s_tick), .t_done_tick(t_done_tick),
        .t_start(t_start), .tx_data(tx_data), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic [3:0] mask;   // requesters that offer one byte
        logic [2:0] n;      // grants expected
        logic [7:0] order;  // grant j expected at order[2j +: 2]
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[4][$];
    logic [7:0] rx_q[$];
    int         gap_meas[$];
    int         to_meas[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         rdy_cnt[4];
    int         to_pulses = 0;
    bit         done_en = 1'b1;
    logic       tx_line = 1'b1;

    // Transmitter model, serial receiver and measurement state.
    int         tick_div = 0;
    bit         m_busy = 0;
    int         m_tick = 0, m_bit = 0;
    logic [7:0] m_shr = '0;
    bit         rx_busy = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    bit         gap_act = 0, to_act = 0, prev_to = 0;
    int         gap_cnt = 0, to_cnt = 0;
    exp_t       e;

    function automatic logic [7:0] data_of(int v, int i);
        return 8'(32 + 16 * v + i);
    endfunction

    function automatic bit srcs_empty();
        for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end else begin
            $display("ok %s value=%0h", name, got);
        end
    endtask

    task automatic wait_idle(string name, int budget);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0 && srcs_empty())) begin
            @(posedge clk); #2;
            k++;
            if (k > budget) begin
                n_cmp++; n_err++;
                $display("FAIL %s_timeout got pending=%0d expected 0", name, exp_q.size());
                exp_q.delete();
                for (int i = 0; i < 4; i++) src_q[i].delete();
                return;
            end
        end
    endtask

    // Everything that reacts to the DUT runs on the falling edge, away from
    // the active edge: the monitor and scoreboard, the requesters, the baud
    // tick, the transmitter model and the serial receiver.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (t_start) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_grant got id=%0d data=%02h expected none", grant_id, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (grant_id !== e.id || tx_data !== e.data || req_ready !== (4'b0001 << e.id)) begin
                            n_err++;
                            $display("FAIL grant got id=%0d data=%02h ready=%b expected id=%0d data=%02h ready=%b",
                                     grant_id, tx_data, req_ready, e.id, e.data, 4'b0001 << e.id);
                        end else begin
                            $display("grant id=%0d data=%02h ready=%b", grant_id, tx_data, req_ready);
                        end
                    end
                    if (gap_act) gap_meas.push_back(gap_cnt);
                    gap_act = 0;
                    to_act  = 1;
                    to_cnt  = 0;
                end else if (req_ready != 4'b0000) begin
                    n_cmp++; n_err++;
                    $display("FAIL stray_ready got ready=%b expected 0000", req_ready);
                end
                for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;
                if (timeout_err) begin
                    if (prev_to) begin
                        n_cmp++; n_err++;
                        $display("FAIL timeout_width got 2+ cycles expected 1");
                    end else begin
                        to_pulses++;
                        if (to_act) to_meas.push_back(to_cnt);
                        to_act = 0;
                    end
                end
                prev_to = timeout_err;
            end

            // Requesters: drop the accepted byte, present the next one.
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i] === 1'b1 && req_valid[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
                req_valid[i] = (src_q[i].size() > 0);
                req_data[i*8 +: 8] = req_valid[i] ? src_q[i][0] : 8'h00;
            end

            // Baud tick every fourth clock.
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            s_tick = (tick_div == 0);
            t_done_tick = 1'b0;

            if (reset) begin
                m_busy = 0; tx_line = 1'b1; rx_busy = 0;
                gap_act = 0; to_act = 0; prev_to = 0;
            end else begin
                if (s_tick) begin
                    if (gap_act) gap_cnt++;
                    if (to_act) to_cnt++;
                end
                // Transmitter: start bit, 8 data bits LSB first, stop bit,
                // each 16 ticks long.
                if (!m_busy) begin
                    if (t_start) begin
                        m_shr = tx_data; m_busy = 1; m_tick = 0; m_bit = 0; tx_line = 1'b0;
                    end
                end else if (s_tick) begin
                    m_tick++;
                    if (m_tick == 16) begin
                        m_tick = 0;
                        m_bit++;
                        if (m_bit == 10) begin
                            m_busy = 0;
                            tx_line = 1'b1;
                            if (done_en) begin
                                t_done_tick = 1'b1;
                                if (req_valid != 4'b0000) begin
                                    gap_act = 1; gap_cnt = 0;
                                end
                            end
                        end else begin
                            tx_line = (m_bit == 9) ? 1'b1 : m_shr[m_bit-1];
                        end
                    end
                end
                // Receiver: sample each bit in its middle.
                if (!rx_busy) begin
                    if (tx_line == 1'b0) begin
                        rx_busy = 1; rx_cnt = 0;
                    end
                end else if (s_tick) begin
                    rx_cnt++;
                    if (rx_cnt % 16 == 8) begin
                        if (rx_cnt / 16 >= 1 && rx_cnt / 16 <= 8) rx_byte[rx_cnt/16 - 1] = tx_line;
                        if (rx_cnt / 16 == 9) begin
                            rx_q.push_back(rx_byte);
                            rx_busy = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        vec_t       vecs[7];
        logic [7:0] hello[5];
        exp_t       x;
        int         lat;
        bit         found;
        logic [1:0] gid_seen;

        vecs[0] = '{4'b1111, 3'd4, 8'hE4};  // 0,1,2,3 from reset
        vecs[1] = '{4'b0010, 3'd1, 8'h01};  // 1
        vecs[2] = '{4'b1011, 3'd3, 8'h13};  // 3,0,1 (wrap)
        vecs[3] = '{4'b0101, 3'd2, 8'h02};  // 2,0
        vecs[4] = '{4'b1001, 3'd2, 8'h03};  // 3,0
        vecs[5] = '{4'b0001, 3'd1, 8'h00};  // 0
        vecs[6] = '{4'b1100, 3'd2, 8'h0E};  // 2,3
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {15'd0, req_ready, t_start, tx_data, grant_id, busy, timeout_err}, 32'd0);
        reset = 1'b0;

        // Round-robin table: all four at once, then pointer-dependent cases.
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                x.id = vecs[v].order[2*j +: 2];
                x.data = data_of(v, int'(x.id));
                exp_q.push_back(x);
            end
            for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) src_q[i].push_back(data_of(v, i));
            wait_idle($sformatf("vec%0d", v), 6000);
        end

        // HELLO from requester 0.
        @(posedge clk); #2;
        rx_q.delete();
        gap_meas.delete();
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
        for (int i = 0; i < 5; i++) begin
            x.id = 2'd0; x.data = hello[i];
            exp_q.push_back(x);
            src_q[0].push_back(hello[i]);
        end
        wait_idle("hello", 8000);
        check("hello_ready0_count", rdy_cnt[0], 5);
        check("hello_other_ready", rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3], 0);
        check("hello_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("hello_rx_byte%0d", i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, hello[i]});

        // Idle gap after done with a request pending: 16..17 ticks.
        check("gap_samples_min4", (gap_meas.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < gap_meas.size(); i++)
            check($sformatf("gap_ticks_in_range%0d", i),
                  (gap_meas[i] >= 16 && gap_meas[i] <= 17) ? 1 : gap_meas[i] + 100, 1);

        // Timeout: transmitter never reports done.
        @(posedge clk); #2;
        done_en = 1'b0;
        to_pulses = 0;
        to_meas.delete();
        x.id = 2'd1; x.data = 8'h5A;
        exp_q.push_back(x);
        src_q[1].push_back(8'h5A);
        wait_idle("timeout", 3000);
        check("timeout_pulses", to_pulses, 1);
        check("timeout_ticks", (to_meas.size() > 0) ? to_meas[0] : -1, 256);
        check("timeout_busy_drop", {31'd0, busy}, 32'd0);
        done_en = 1'b1;
        x.id = 2'd2; x.data = 8'hA5;
        exp_q.push_back(x);
        src_q[2].push_back(8'hA5);
        wait_idle("after_timeout", 3000);
        check("no_extra_timeout", to_pulses, 1);

        // Reset in the middle of a frame.
        @(posedge clk); #2;
        x.id = 2'd1; x.data = 8'h33;
        exp_q.push_back(x);
        src_q[1].push_back(8'h33);
        lat = 0;
        while (exp_q.size() != 0 && lat < 50) begin
            @(posedge clk); #2;
            lat++;
        end
        repeat (20) @(posedge clk);
        #2;
        check("mid_frame_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {15'd0, req_ready, t_start, tx_data, grant_id, busy, timeout_err}, 32'd0);
        x.id = 2'd2; x.data = 8'h77;
        exp_q.push_back(x);
        src_q[2].push_back(8'h77);
        repeat (3) @(posedge clk);
        #2;
        check("reset_held_outputs", {15'd0, req_ready, t_start, tx_data, grant_id, busy, timeout_err}, 32'd0);
        reset = 1'b0;
        found = 0;
        gid_seen = '0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #2;
            if (t_start && !found) begin
                found = 1;
                gid_seen = grant_id;
            end
        end
        check("restart_t_start_within_2clk", {31'd0, found}, 32'd1);
        check("restart_grant_id", {30'd0, gid_seen}, 32'd2);
        wait_idle("after_reset", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
